// File: rtl/reel_selector_if.sv
// Pin bundle between the reel selector and its buttons/display: start/stop pulses in, digit drive and status out.
// The master drives the button pulses; the slave (the reel selector) drives the display and status.
interface reel_selector_if #(
    parameter int NUM_REELS = 6
);
    logic                 start;
    logic [NUM_REELS-1:0] stop;
    logic [NUM_REELS-1:0] digit_cath;
    logic [7:0]           digit_seg;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output stop,
        input  digit_cath,
        input  digit_seg,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        output digit_cath,
        output digit_seg,
        output busy,
        output done
    );
endinterface

// File: rtl/reel_selector.sv
// Digit reels stopped highest-index-first, then flash and hold on a scanned 7-segment display; REEL_SELECTOR_HEX_EN gives 0..F reels.
// Display and status are registered (one cycle after slot/state change); inputs are single-cycle pulses with no backpressure.
module reel_selector #(
    parameter int NUM_REELS     = 6,
    parameter int STEP_BASE     = 1250000,
    parameter int STEP_INC      = 250000,
    parameter int SCAN_DIV      = 50000,
    parameter int FLASH_DIV     = 12500000,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic           clk,
    input  logic           rst,
    reel_selector_if.slave bus
);

    localparam int MAX_PER = STEP_BASE + (NUM_REELS - 1) * STEP_INC;
    localparam int SW      = $clog2(MAX_PER + 1);
    localparam int CW      = $clog2(SCAN_DIV + 1);
    localparam int FW      = $clog2(FLASH_DIV + 1);
    localparam int SLW     = $clog2(NUM_REELS);
    localparam int TW      = 4;

`ifdef REEL_SELECTOR_HEX_EN
    localparam logic [3:0] REEL_MAX = 4'hF;
`else
    localparam logic [3:0] REEL_MAX = 4'd9;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        FLASH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [3:0]             reel     [NUM_REELS];
    logic [SW-1:0]          step_cnt [NUM_REELS];
    logic [NUM_REELS-1:0]   running;
    logic [NUM_REELS-1:0]   honour;

    logic [CW-1:0]          scan_cnt;
    logic [SLW-1:0]         slot;
    logic [FW-1:0]          flash_cnt;
    logic [TW-1:0]          toggle_cnt;
    logic                   flash_wrap;

    logic                   spin_entry;
    logic                   blank;
    logic [NUM_REELS-1:0]   slot_onehot;

    logic [NUM_REELS-1:0]   cath_q;
    logic [7:0]             seg_q;
    logic                   busy_q;
    logic                   done_q;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'h0:    p = 8'b1111_1100;
            4'h1:    p = 8'b0110_0000;
            4'h2:    p = 8'b1101_1010;
            4'h3:    p = 8'b1111_0010;
            4'h4:    p = 8'b0110_0110;
            4'h5:    p = 8'b1011_0110;
            4'h6:    p = 8'b1011_1110;
            4'h7:    p = 8'b1110_0000;
            4'h8:    p = 8'b1111_1110;
            4'h9:    p = 8'b1111_0110;
`ifdef REEL_SELECTOR_HEX_EN
            4'hA:    p = 8'b1110_1110;
            4'hB:    p = 8'b0011_1110;
            4'hC:    p = 8'b1001_1100;
            4'hD:    p = 8'b0111_1010;
            4'hE:    p = 8'b1001_1110;
            4'hF:    p = 8'b1000_1110;
`endif
            default: p = 8'b0000_0000;
        endcase
        return p;
    endfunction

    // Only the highest still-running reel may accept a stop, so at most one bit is set.
    always_comb begin
        honour = '0;
        if (state == SPIN) begin
            for (int i = 0; i < NUM_REELS; i++) begin
                honour[i] = bus.stop[i] && running[i] && ((running >> (i + 1)) == '0);
            end
        end
    end

    assign flash_wrap = (flash_cnt == FW'(FLASH_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        spin_entry = 1'b0;
        blank      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = SPIN;
                    spin_entry = 1'b1;
                end
            end
            SPIN: begin
                if (honour[0]) begin
                    state_nxt = FLASH;
                end
            end
            FLASH: begin
                blank = ~toggle_cnt[0];
                if (flash_wrap && (toggle_cnt == TW'(FLASH_TOGGLES - 1))) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.start) begin
                    state_nxt  = SPIN;
                    spin_entry = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A stop honoured this cycle wins over a step that falls due in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= '0;
            for (int i = 0; i < NUM_REELS; i++) begin
                reel[i]     <= '0;
                step_cnt[i] <= '0;
            end
        end else if (spin_entry) begin
            running <= '1;
            for (int i = 0; i < NUM_REELS; i++) begin
                reel[i]     <= '0;
                step_cnt[i] <= '0;
            end
        end else if (state == SPIN) begin
            for (int i = 0; i < NUM_REELS; i++) begin
                if (honour[i]) begin
                    running[i] <= 1'b0;
                end else if (running[i]) begin
                    if (step_cnt[i] == SW'(STEP_BASE + i * STEP_INC - 1)) begin
                        step_cnt[i] <= '0;
                        reel[i]     <= (reel[i] == REEL_MAX) ? 4'd0 : reel[i] + 4'd1;
                    end else begin
                        step_cnt[i] <= step_cnt[i] + SW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_cnt  <= '0;
            toggle_cnt <= '0;
        end else if (state == SPIN && honour[0]) begin
            flash_cnt  <= '0;
            toggle_cnt <= '0;
        end else if (state == FLASH) begin
            if (flash_wrap) begin
                flash_cnt  <= '0;
                toggle_cnt <= toggle_cnt + TW'(1);
            end else begin
                flash_cnt  <= flash_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            slot     <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            slot     <= (slot == SLW'(NUM_REELS - 1)) ? '0 : slot + SLW'(1);
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    assign slot_onehot = {{(NUM_REELS - 1){1'b0}}, 1'b1} << slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cath_q <= '1;
            seg_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cath_q <= blank ? '1 : ~slot_onehot;
            seg_q  <= seg_decode(reel[slot]);
            busy_q <= (state_nxt == SPIN) || (state_nxt == FLASH);
            done_q <= (state_nxt == HOLD);
        end
    end

    assign bus.digit_cath = cath_q;
    assign bus.digit_seg  = seg_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_reel_selector.sv
// Bench for reel_selector: per-cycle display/status expectations queued at stimulus time, popped and compared after each clock.
`timescale 1ns/1ps
module tb_reel_selector;

    localparam int NR = 4;
    localparam int SB = 10;
    localparam int SI = 2;
    localparam int SD = 4;
    localparam int FD = 8;
    localparam int FT = 6;
`ifdef REEL_SELECTOR_HEX_EN
    localparam int MODV = 16;
`else
    localparam int MODV = 10;
`endif
    localparam int NEVER = 1 << 30;

    typedef struct packed {
        logic [3:0] cath;
        logic [7:0] seg;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reel_selector_if #(.NUM_REELS(NR)) bus ();

    reel_selector #(
        .NUM_REELS    (NR),
        .STEP_BASE    (SB),
        .STEP_INC     (SI),
        .SCAN_DIV     (SD),
        .FLASH_DIV    (FD),
        .FLASH_TOGGLES(FT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the display slot follows directly from it.
    int scan_n;
    always @(posedge clk or negedge rst) begin
        if (!rst) scan_n <= 0;
        else      scan_n <= scan_n + 1;
    end

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    int               fr[NR];
    int               flash_t;
    logic [NR-1:0]    rm;
    int               spin_base;

    function automatic logic [7:0] seg_of(input int v);
        case (v)
            0:  return 8'b1111_1100;
            1:  return 8'b0110_0000;
            2:  return 8'b1101_1010;
            3:  return 8'b1111_0010;
            4:  return 8'b0110_0110;
            5:  return 8'b1011_0110;
            6:  return 8'b1011_1110;
            7:  return 8'b1110_0000;
            8:  return 8'b1111_1110;
            9:  return 8'b1111_0110;
            10: return 8'b1110_1110;
            11: return 8'b0011_1110;
            12: return 8'b1001_1100;
            13: return 8'b0111_1010;
            14: return 8'b1001_1110;
            15: return 8'b1000_1110;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] cath_for(input int n);
        logic [3:0] oh;
        oh = 4'b0001 << (((n - 1) / SD) % NR);
        return ~oh;
    endfunction

    // Reel i value after u edges of SPIN; a stop honoured at edge fr freezes the value held after edge fr-1.
    function automatic int reel_at(input int i, input int u);
        int x;
        x = (fr[i] != NEVER && u >= fr[i]) ? fr[i] - 1 : u;
        return (x / (SB + i * SI)) % MODV;
    endfunction

    function automatic exp_t spin_exp(input int t);
        exp_t e;
        int   n, sl, j;
        logic in_flash_done, blank;
        n  = spin_base + t;
        sl = ((n - 1) / SD) % NR;
        j  = (flash_t == NEVER) ? -1 : t - flash_t;
        blank         = (j >= 1) && (j <= FT * FD) && (((j - 1) / FD) % 2 == 0);
        in_flash_done = (j >= FT * FD);
        e.cath = blank ? 4'hF : cath_for(n);
        e.seg  = seg_of(reel_at(sl, t - 1));
        e.busy = !in_flash_done;
        e.done = in_flash_done;
        return e;
    endfunction

    task automatic test_reset();
        bus.start = 1'b0;
        bus.stop  = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.digit_cath !== 4'hF) begin fails++; $display("FAIL reset_cath: got %b expected 1111", bus.digit_cath); end
        checks++; if (bus.digit_seg !== 8'h00)  begin fails++; $display("FAIL reset_seg: got %h expected 00", bus.digit_seg); end
        checks++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)        begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b1;
    endtask

    task automatic test_scan_idle();
        exp_t e, g;
        for (int c = 0; c < 32; c++) begin
            e.cath = cath_for(scan_n + 1);
            e.seg  = 8'b1111_1100;
            e.busy = 1'b0;
            e.done = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            g = {bus.digit_cath, bus.digit_seg, bus.busy, bus.done};
            e = sb.pop_front();
            checks++; if (g.cath !== e.cath) begin fails++; $display("FAIL idle_scan_cath c=%0d: got %b expected %b", c, g.cath, e.cath); end
            checks++; if (g.seg  !== e.seg)  begin fails++; $display("FAIL idle_scan_seg c=%0d: got %h expected %h", c, g.seg, e.seg); end
            checks++; if (g.busy !== e.busy) begin fails++; $display("FAIL idle_busy c=%0d: got %b expected %b", c, g.busy, e.busy); end
        end
    endtask

    task automatic test_spin_stop_flash();
        exp_t          e, g;
        logic [NR-1:0] m;
        int            h;
        for (int i = 0; i < NR; i++) fr[i] = NEVER;
        flash_t = NEVER;
        rm      = '1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        spin_base = scan_n;
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL spin_entry_busy: got %b expected 1", bus.busy); end
        for (int t = 1; t <= 125 + FT * FD + 20; t++) begin
            case (t)
                20:      m = 4'b0001;
                40:      m = 4'b1000;
                55:      m = 4'b0110;
                70:      m = 4'b0010;
                80:      m = 4'b0100;
                125:     m = 4'b0001;
                default: m = 4'b0000;
            endcase
            bus.stop  = m;
            bus.start = (t == 30) || (t == 135);
            h = -1;
            for (int i = NR - 1; i >= 0; i--) if (rm[i] && h < 0) h = i;
            if (flash_t == NEVER && h >= 0 && m[h]) begin
                fr[h] = t;
                rm[h] = 1'b0;
                if (h == 0) flash_t = t;
            end
            sb.push_back(spin_exp(t));
            @(negedge clk);
            bus.stop  = '0;
            bus.start = 1'b0;
            g = {bus.digit_cath, bus.digit_seg, bus.busy, bus.done};
            e = sb.pop_front();
            checks++; if (g.cath !== e.cath) begin fails++; $display("FAIL spin_cath t=%0d: got %b expected %b", t, g.cath, e.cath); end
            checks++; if (g.seg  !== e.seg)  begin fails++; $display("FAIL spin_seg t=%0d: got %h expected %h", t, g.seg, e.seg); end
            checks++; if (g.busy !== e.busy) begin fails++; $display("FAIL spin_busy t=%0d: got %b expected %b", t, g.busy, e.busy); end
            checks++; if (g.done !== e.done) begin fails++; $display("FAIL spin_done t=%0d: got %b expected %b", t, g.done, e.done); end
        end
    endtask

    task automatic test_restart_from_hold();
        exp_t e, g;
        int   base;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        base = scan_n;
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL restart_done: got %b expected 0", bus.done); end
        for (int t = 1; t <= 9; t++) begin
            e.cath = cath_for(base + t);
            e.seg  = 8'b1111_1100;
            e.busy = 1'b1;
            e.done = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            g = {bus.digit_cath, bus.digit_seg, bus.busy, bus.done};
            e = sb.pop_front();
            checks++; if (g.cath !== e.cath) begin fails++; $display("FAIL restart_cath t=%0d: got %b expected %b", t, g.cath, e.cath); end
            checks++; if (g.seg  !== e.seg)  begin fails++; $display("FAIL restart_seg t=%0d: got %h expected %h", t, g.seg, e.seg); end
        end
    endtask

    task automatic test_reset_mid_spin();
        exp_t e, g;
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.digit_cath !== 4'hF) begin fails++; $display("FAIL midspin_rst_cath: got %b expected 1111", bus.digit_cath); end
        checks++; if (bus.digit_seg !== 8'h00)  begin fails++; $display("FAIL midspin_rst_seg: got %h expected 00", bus.digit_seg); end
        checks++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL midspin_rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)        begin fails++; $display("FAIL midspin_rst_done: got %b expected 0", bus.done); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            e.cath = cath_for(c);
            e.seg  = 8'b1111_1100;
            e.busy = 1'b0;
            e.done = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            g = {bus.digit_cath, bus.digit_seg, bus.busy, bus.done};
            e = sb.pop_front();
            checks++; if (g.cath !== e.cath) begin fails++; $display("FAIL post_rst_cath c=%0d: got %b expected %b", c, g.cath, e.cath); end
            checks++; if (g.busy !== e.busy) begin fails++; $display("FAIL post_rst_busy c=%0d: got %b expected %b", c, g.busy, e.busy); end
        end
    endtask

    task automatic test_reset_mid_flash();
        logic [NR-1:0] seq;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = NR - 1; k >= 0; k--) begin
            seq    = '0;
            seq[k] = 1'b1;
            bus.stop = seq;
            @(negedge clk);
        end
        bus.stop = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1)        begin fails++; $display("FAIL flash_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.digit_cath !== 4'hF) begin fails++; $display("FAIL flash_blank: got %b expected 1111", bus.digit_cath); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.digit_cath !== 4'hF) begin fails++; $display("FAIL midflash_rst_cath: got %b expected 1111", bus.digit_cath); end
        checks++; if (bus.digit_seg !== 8'h00)  begin fails++; $display("FAIL midflash_rst_seg: got %h expected 00", bus.digit_seg); end
        checks++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL midflash_rst_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.digit_cath !== 4'b1110) begin fails++; $display("FAIL midflash_first_slot: got %b expected 1110", bus.digit_cath); end
        checks++; if (bus.busy !== 1'b0)          begin fails++; $display("FAIL midflash_idle_busy: got %b expected 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = '0;
        test_reset();
        test_scan_idle();
        test_spin_stop_flash();
        test_restart_from_hold();
        test_reset_mid_spin();
        test_reset_mid_flash();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
